// File: rtl/div_recon_pkg.sv
// Shared types and sizing for the divider reconstruction checker.
// Optional MSE accumulation is enabled by defining DIV_RECON_MSE_ACC_EN.
package div_recon_pkg;

  localparam int N_W_DEFAULT = 8;
  localparam int SQ_ACC_W    = 48;
  localparam int CNT_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Signed error carries one extra bit over the 2*N_W dividend.
  function automatic int err_width(input int n_w);
    return 2 * n_w + 1;
  endfunction

endpackage

// File: rtl/div_recon_shift_add_step.sv
// One shift-add multiply step: conditionally add the shifted divisor, then advance both shifters.
module div_recon_shift_add_step
  import div_recon_pkg::*;
#(
  parameter int N_W = N_W_DEFAULT
) (
  input  logic [2*N_W-1:0] acc,
  input  logic [2*N_W-1:0] d_sh,
  input  logic [N_W-1:0]   q_sh,
  output logic [2*N_W-1:0] acc_nxt,
  output logic [2*N_W-1:0] d_sh_nxt,
  output logic [N_W-1:0]   q_sh_nxt
);

  assign acc_nxt  = q_sh[0] ? (acc + d_sh) : acc;
  assign d_sh_nxt = d_sh << 1;
  assign q_sh_nxt = q_sh >> 1;

endmodule

// File: rtl/divider_array_reconstruct_seq.sv
// Rebuilds n_hat = q*d + r with a sequential shift-add multiplier and reports err = n_hat - n.
// Defining DIV_RECON_MSE_ACC_EN adds saturating sum-of-squared-error and sample counters.
//
// state | meaning
// IDLE  | ready for operands
// MUL   | one shift-add step per cycle, N_W steps
// ADD   | add remainder, register n_hat / err / exact
// DONE  | result valid, held until out_ready
module divider_array_reconstruct_seq
  import div_recon_pkg::*;
#(
  parameter int N_W = N_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*N_W-1:0]          n,
  input  logic [N_W-1:0]            d,
  input  logic [N_W-1:0]            q,
  input  logic [N_W-1:0]            r,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*N_W-1:0]          n_hat,
  output logic [err_width(N_W)-1:0] err,
  output logic                      exact,
  input  logic                      acc_clr,
  output logic [SQ_ACC_W-1:0]       sq_acc,
  output logic [CNT_W-1:0]          cnt
);

  localparam int NN_W   = 2 * N_W;
  localparam int ERR_W  = err_width(N_W);
  localparam int STEP_W = $clog2(N_W + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_W - 1);

  state_t            state, state_nxt;
  logic [NN_W-1:0]   n_r, d_sh, acc, acc_step, d_sh_step, n_hat_nxt;
  logic [N_W-1:0]    q_sh, q_sh_step, r_r;
  logic [STEP_W-1:0] step_cnt;
  logic [ERR_W-1:0]  err_nxt;
  logic              accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MUL;
      MUL:  if (step_cnt == '0) state_nxt = ADD;
      ADD:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gate ready with rst_n so it stays low for the whole reset pulse.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready  = rst_n;
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  div_recon_shift_add_step #(.N_W(N_W)) u_step (
    .acc      (acc),
    .d_sh     (d_sh),
    .q_sh     (q_sh),
    .acc_nxt  (acc_step),
    .d_sh_nxt (d_sh_step),
    .q_sh_nxt (q_sh_step)
  );

  assign n_hat_nxt = acc + NN_W'(r_r);
  assign err_nxt   = {1'b0, n_hat_nxt} - {1'b0, n_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r      <= '0;
      d_sh     <= '0;
      q_sh     <= '0;
      r_r      <= '0;
      acc      <= '0;
      step_cnt <= '0;
      n_hat    <= '0;
      err      <= '0;
      exact    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          n_r      <= n;
          d_sh     <= NN_W'(d);
          q_sh     <= q;
          r_r      <= r;
          acc      <= '0;
          step_cnt <= STEP_LAST;
        end
        MUL: begin
          acc  <= acc_step;
          d_sh <= d_sh_step;
          q_sh <= q_sh_step;
          if (step_cnt != '0) step_cnt <= step_cnt - 1'b1;
        end
        ADD: begin
          n_hat <= n_hat_nxt;
          err   <= err_nxt;
          exact <= (n_hat_nxt == n_r);
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_RECON_MSE_ACC_EN
  localparam int SQ_W  = 2 * ERR_W;
  localparam int SUM_W = ((SQ_W > SQ_ACC_W) ? SQ_W : SQ_ACC_W) + 1;

  logic [ERR_W-1:0]    err_mag;
  logic [SQ_W-1:0]     err_sq;
  logic [SUM_W-1:0]    sq_sum;
  logic [SQ_ACC_W-1:0] sq_acc_r;
  logic [CNT_W-1:0]    cnt_r;

  assign err_mag = err_nxt[ERR_W-1] ? -err_nxt : err_nxt;
  assign err_sq  = SQ_W'(err_mag) * SQ_W'(err_mag);
  assign sq_sum  = SUM_W'(sq_acc_r) + SUM_W'(err_sq);

  // Clear has priority over a coincident ADD sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_acc_r <= '0;
      cnt_r    <= '0;
    end else if (acc_clr) begin
      sq_acc_r <= '0;
      cnt_r    <= '0;
    end else if (state == ADD) begin
      sq_acc_r <= (sq_sum > SUM_W'({SQ_ACC_W{1'b1}})) ? '1 : sq_sum[SQ_ACC_W-1:0];
      if (cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign sq_acc = sq_acc_r;
  assign cnt    = cnt_r;
`else
  logic acc_clr_unused;
  assign acc_clr_unused = acc_clr;
  assign sq_acc = '0;
  assign cnt    = '0;
`endif

endmodule
